// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined unsigned multiplier among NREQ requesters.
// One issue per cycle; each product returns as a one-cycle pulse tagged with its requester id.
module mult_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3,
  parameter int LAT   = 2,
  parameter int IDW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [2*WIDTH-1:0]    o_rsp_data,
  output logic                  o_busy,
  output logic [15:0]           o_op_count
);

  // Handshake: a transfer happens on requester k in any cycle where i_req_valid[k] and
  // o_req_ready[k] are both high; ready is only raised for a requester already showing
  // valid, so requesters may drop valid before a transfer and simply lose the slot.

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_found;
  logic               accept;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [2*WIDTH-1:0] prod;

  logic [LAT-1:0]     stg_vld;
  logic [IDW-1:0]     stg_id   [LAT];
  logic [2*WIDTH-1:0] stg_data [LAT];
  logic [LAT-1:0]     in_vld;
  logic [IDW-1:0]     in_id    [LAT];
  logic [2*WIDTH-1:0] in_data  [LAT];

  // Two-pass search: first the indices at or above the pointer, then wrap to the bottom.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && i_req_valid[k] && (k >= int'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && i_req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(k);
      end
    end
  end

  // Gating with the reset input keeps ready low for the whole time reset is held.
  assign accept = gnt_found && i_en && i_reset_n;

  always_comb begin
    o_req_ready = '0;
    a_sel       = '0;
    b_sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        o_req_ready[k] = accept;
        a_sel          = i_req_a[k*WIDTH +: WIDTH];
        b_sel          = i_req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign prod     = (2*WIDTH)'(a_sel) * (2*WIDTH)'(b_sel);
  assign ptr_next = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

  always_comb begin
    in_vld    = '0;
    in_id     = '{default: '0};
    in_data   = '{default: '0};
    in_vld[0]  = accept;
    in_id[0]   = gnt_id;
    in_data[0] = prod;
    for (int i = 1; i < LAT; i++) begin
      in_vld[i]  = stg_vld[i-1];
      in_id[i]   = stg_id[i-1];
      in_data[i] = stg_data[i-1];
    end
  end

  // The last stage only loads on a valid op so id/data hold the previous response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr     <= '0;
      o_op_count <= '0;
      stg_vld    <= '0;
      for (int i = 0; i < LAT; i++) begin
        stg_id[i]   <= '0;
        stg_data[i] <= '0;
      end
    end else begin
      stg_vld <= in_vld;
      for (int i = 0; i < LAT; i++) begin
        if ((i < LAT-1) || in_vld[i]) begin
          stg_id[i]   <= in_id[i];
          stg_data[i] <= in_data[i];
        end
      end
      if (accept) begin
        rr_ptr     <= ptr_next;
        o_op_count <= o_op_count + 16'd1;
      end
    end
  end

  assign o_rsp_id   = stg_id[LAT-1];
  assign o_rsp_data = stg_data[LAT-1];
  assign o_busy     = |stg_vld;

  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (stg_vld[LAT-1] && (stg_id[LAT-1] == IDW'(k))) o_rsp_valid[k] = 1'b1;
    end
  end

endmodule
